// File: rtl/uart_debug_dumper_pkg.sv
// Shared constants for the debug dumper: frame layout, header codes and FSM encoding.
package uart_debug_dumper_pkg;

  localparam logic [7:0] HDR_OK    = 8'hA5;
  localparam logic [7:0] HDR_DROP  = 8'hA7;
  localparam int         FRAME_LEN = 10;

  localparam logic [3:0] IDX_HDR    = 4'd0;
  localparam logic [3:0] IDX_PC_HI  = 4'd1;
  localparam logic [3:0] IDX_PC_LO  = 4'd2;
  localparam logic [3:0] IDX_ACC_HI = 4'd3;
  localparam logic [3:0] IDX_ACC_LO = 4'd4;
  localparam logic [3:0] IDX_CNT_B3 = 4'd5;
  localparam logic [3:0] IDX_CNT_B2 = 4'd6;
  localparam logic [3:0] IDX_CNT_B1 = 4'd7;
  localparam logic [3:0] IDX_CNT_B0 = 4'd8;
  localparam logic [3:0] IDX_CSUM   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // XOR over the payload bytes (everything between header and checksum).
  function automatic logic [7:0] frame_checksum(input logic [15:0] pc,
                                                input logic [15:0] acc,
                                                input logic [31:0] cnt);
    return pc[15:8] ^ pc[7:0] ^ acc[15:8] ^ acc[7:0]
         ^ cnt[31:24] ^ cnt[23:16] ^ cnt[15:8] ^ cnt[7:0];
  endfunction

endpackage

// File: rtl/dbg_cycle_counter.sv
// Free-running 32-bit cycle counter; wraps naturally from all-ones to zero.
module dbg_cycle_counter (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] count
);

  logic [31:0] count_next;

  assign count_next = count + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= 32'd0;
    else        count <= count_next;
  end

endmodule

// File: rtl/uart_debug_dumper.sv
// Snapshots PC/ACC/cycle count on each debug strobe and streams a 10-byte
// frame into a byte-wide UART TX with a start/done handshake.
module uart_debug_dumper
  import uart_debug_dumper_pkg::*;
#(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_uart,
  input  logic [AB-1:0] pc_in,
  input  logic [DB-1:0] acc_in,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_done,
  output logic          busy,
  output logic          overrun
);

  // Handshake: tx_start is high for the single LOAD cycle with tx_data valid;
  // tx_data then holds until the TX answers with a one-cycle tx_done in WAIT.
  // tx_done seen in IDLE or LOAD carries no meaning and is ignored.

  state_t      state, state_next;
  logic [3:0]  idx, idx_next;
  logic [31:0] cycle_cnt;
  logic        capture, drop, drop_flag;
  logic [7:0]  snap_hdr, snap_csum, byte_sel;
  logic [15:0] snap_pc, snap_acc;
  logic [31:0] snap_cnt;

  dbg_cycle_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .count (cycle_cnt)
  );

  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_uart) begin
          capture    = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: state_next = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          if (idx == 4'(FRAME_LEN - 1)) begin
            idx_next   = 4'd0;
            state_next = ST_IDLE;
          end else begin
            idx_next   = idx + 4'd1;
            state_next = ST_LOAD;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Any strobe that cannot start a frame is lost, including the cycle of the final done.
  assign drop = wr_uart && (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= 4'd0;
      drop_flag <= 1'b0;
      overrun   <= 1'b0;
      snap_hdr  <= 8'h00;
      snap_pc   <= 16'h0000;
      snap_acc  <= 16'h0000;
      snap_cnt  <= 32'd0;
      snap_csum <= 8'h00;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (capture)   drop_flag <= 1'b0;
      else if (drop) drop_flag <= 1'b1;
      if (drop) overrun <= 1'b1;
      if (capture) begin
        snap_hdr  <= drop_flag ? HDR_DROP : HDR_OK;
        snap_pc   <= 16'(pc_in);
        snap_acc  <= 16'(acc_in);
        snap_cnt  <= cycle_cnt;
        snap_csum <= frame_checksum(16'(pc_in), 16'(acc_in), cycle_cnt);
      end
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      IDX_HDR:    byte_sel = snap_hdr;
      IDX_PC_HI:  byte_sel = snap_pc[15:8];
      IDX_PC_LO:  byte_sel = snap_pc[7:0];
      IDX_ACC_HI: byte_sel = snap_acc[15:8];
      IDX_ACC_LO: byte_sel = snap_acc[7:0];
      IDX_CNT_B3: byte_sel = snap_cnt[31:24];
      IDX_CNT_B2: byte_sel = snap_cnt[23:16];
      IDX_CNT_B1: byte_sel = snap_cnt[15:8];
      IDX_CNT_B0: byte_sel = snap_cnt[7:0];
      IDX_CSUM:   byte_sel = snap_csum;
      default:    byte_sel = 8'h00;
    endcase
  end

  assign tx_data  = (state == ST_IDLE) ? 8'h00 : byte_sel;
  assign tx_start = (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_debug_dumper.sv
// Directed bench for uart_debug_dumper: a UART TX model answers each tx_start
// after 16 cycles and records every launched byte for the scoreboard.
module tb_uart_debug_dumper;

  localparam int DONE_DLY = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_uart = 1'b0;
  logic [10:0] pc_in = 11'h000;
  logic [15:0] acc_in = 16'h0000;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] mcnt;

  bit   done_with_start = 1'b0;
  bit   stray_done = 1'b0;
  int   proto_err = 0;

  uart_debug_dumper #(.AB(11), .DB(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_uart  (wr_uart),
    .pc_in    (pc_in),
    .acc_in   (acc_in),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy),
    .overrun  (overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference cycle counter: zero in reset, +1 on every clock afterwards.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 32'd0;
    else        mcnt <= mcnt + 32'd1;
  end

  // ---------------- UART TX model ----------------
  bit         pending = 1'b0;
  bit         prev_start = 1'b0;
  bit         prev_busy = 1'b0;
  int         dcnt = 0;
  int         cyc = 0;
  int         last_done_cyc = -100;
  logic [7:0] hold = 8'h00;

  always @(negedge clk) begin
    cyc++;
    tx_done = 1'b0;
    if (!rst_n) begin
      pending = 1'b0;
      prev_start = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (tx_start) begin
        got_q.push_back(tx_data);
        if (prev_start) proto_err++;
        if (prev_busy && cyc != last_done_cyc + 1) proto_err++;
        hold = tx_data;
        pending = 1'b1;
        dcnt = DONE_DLY;
        if (done_with_start) begin
          tx_done = 1'b1;
          done_with_start = 1'b0;
        end
      end else if (pending) begin
        if (tx_data !== hold) proto_err++;
        dcnt--;
        if (dcnt == 0) begin
          tx_done = 1'b1;
          pending = 1'b0;
          last_done_cyc = cyc;
        end
      end else if (stray_done) begin
        tx_done = 1'b1;
        stray_done = 1'b0;
      end
      prev_start = tx_start;
      prev_busy = busy;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic void push_frame(input logic [7:0] hdr, input logic [15:0] pc,
                                     input logic [15:0] acc, input logic [31:0] cnt);
    logic [7:0] b[10];
    b[0] = hdr;
    b[1] = pc[15:8];   b[2] = pc[7:0];
    b[3] = acc[15:8];  b[4] = acc[7:0];
    b[5] = cnt[31:24]; b[6] = cnt[23:16]; b[7] = cnt[15:8]; b[8] = cnt[7:0];
    b[9] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7] ^ b[8];
    foreach (b[i]) exp_q.push_back(b[i]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_uart = 1'b0;
    repeat (2) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; pc/acc are scrambled afterwards to prove the snapshot is frozen.
  task automatic send_req(input logic [10:0] pc, input logic [15:0] acc, input logic [7:0] hdr);
    pc_in = pc;
    acc_in = acc;
    wr_uart = 1'b1;
    push_frame(hdr, {5'b0, pc}, acc, mcnt);
    @(negedge clk);
    wr_uart = 1'b0;
    pc_in = ~pc;
    acc_in = ~acc;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (got_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_frame(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (got_q.size() >= n && !busy) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (dut.u_cnt.count !== 32'd3) begin errors++; $display("FAIL reset_cycle_cnt: got %08h want 00000003", dut.u_cnt.count); end
  endtask

  task automatic test_basic_frame();
    logic [7:0] lit[10] = '{8'hA5, 8'h00, 8'h05, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h10, 8'h33};
    bit ok;
    do_reset();
    repeat (16) @(negedge clk);
    foreach (lit[i]) exp_q.push_back(lit[i]);
    pc_in = 11'h005;
    acc_in = 16'h1234;
    wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL basic_latency: tx_start %b want 1", tx_start); end
    pc_in = 11'h7AA;
    acc_in = 16'hFFFF;
    wait_frame(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: bytes %0d busy %b", got_q.size(), busy); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_drop_overrun();
    bit ok;
    do_reset();
    repeat (3) @(negedge clk);
    send_req(11'h3A1, 16'hC0DE, 8'hA5);
    wait_bytes(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout_byte3: bytes %0d", got_q.size()); end
    wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL drop_overrun: got %b want 1", overrun); end
    wait_frame(10, ok);
    send_req(11'h012, 16'h0345, 8'hA7);
    wait_frame(20, ok);
    send_req(11'h6F0, 16'h8001, 8'hA5);
    wait_frame(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout: bytes %0d busy %b", got_q.size(), busy); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL drop_overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_held_strobe();
    bit ok;
    do_reset();
    repeat (2) @(negedge clk);
    pc_in = 11'h155;
    acc_in = 16'hAA55;
    push_frame(8'hA5, 16'h0155, 16'hAA55, mcnt);
    wr_uart = 1'b1;
    repeat (5) @(negedge clk);
    wr_uart = 1'b0;
    wait_frame(10, ok);
    repeat (40) @(negedge clk);
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL held_frame_count: got %0d bytes want 10", got_q.size()); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL held_overrun: got %b want 1", overrun); end
    send_req(11'h001, 16'h0002, 8'hA7);
    wait_frame(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL held_timeout: bytes %0d busy %b", got_q.size(), busy); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL held_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL held_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_handshake();
    bit ok;
    do_reset();
    repeat (4) @(negedge clk);
    done_with_start = 1'b1;
    send_req(11'h2C3, 16'h5A5A, 8'hA5);
    wait_frame(10, ok);
    stray_done = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0 || got_q.size() != 10) begin errors++; $display("FAIL hs_stray_done: busy %b bytes %0d want 0/10", busy, got_q.size()); end
    send_req(11'h0F0, 16'h1357, 8'hA5);
    wait_frame(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hs_timeout: bytes %0d busy %b", got_q.size(), busy); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL hs_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL hs_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (proto_err != 0) begin errors++; $display("FAIL hs_protocol: %0d start-width/stability/gap violations, want 0", proto_err); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    repeat (2) @(negedge clk);
    send_req(11'h123, 16'h4567, 8'hA5);
    wait_bytes(2, ok);
    wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
    wait_bytes(7, ok);
    checks++; if (!ok || overrun !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: bytes %0d overrun %b", got_q.size(), overrun); end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_start: got %b want 0", tx_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun: got %b want 0", overrun); end
    repeat (2) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_mid_resumed: got %0d bytes want 0", got_q.size()); end
    send_req(11'h321, 16'h7654, 8'hA5);
    wait_frame(10, ok);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_mid_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] lit[10] = '{8'hA5, 8'h07, 8'hFF, 8'hBE, 8'hEF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA9};
    bit ok;
    do_reset();
    repeat (5) @(negedge clk);
    force dut.u_cnt.count_next = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_cnt.count_next;
    checks++; if (dut.u_cnt.count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %08h want FFFFFFFF", dut.u_cnt.count); end
    foreach (lit[i]) exp_q.push_back(lit[i]);
    pc_in = 11'h7FF;
    acc_in = 16'hBEEF;
    wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
    checks++; if (dut.u_cnt.count !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next: got %08h want 00000000", dut.u_cnt.count); end
    wait_frame(10, ok);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_frame();
    test_drop_overrun();
    test_held_strobe();
    test_handshake();
    test_reset_mid_frame();
    test_wrap();
    checks++; if (proto_err != 0) begin errors++; $display("FAIL protocol_total: %0d violations want 0", proto_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_debug_dumper.md
Name: uart_debug_dumper

Overview:
- Consumer end of the CPU's debug strobe: on each `wr_uart` pulse from the control path, it snapshots PC, accumulator and a free-running cycle count.
- It serialises the snapshot as a fixed 10-byte frame into the byte-wide UART transmitter, using a start/done handshake.
- It sits between the CPU core (Control_Block/datapath) and the UART TX.
- It never stalls the CPU. Strobes arriving while a frame is in flight are dropped and flagged.

Parameters:
- AB, 11, program-counter width (1..16); zero-extended to 16 bits in the frame.
- DB, 16, accumulator width (1..16); zero-extended to 16 bits in the frame.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_uart  in  1  dump request, sampled each cycle while high
- pc_in  in  AB  current program counter
- acc_in  in  DB  current accumulator
- tx_data  out  8  byte to UART TX, held stable from tx_start until tx_done
- tx_start  out  1  one-cycle pulse, launches tx_data
- tx_done  in  1  one-cycle pulse from UART TX: byte fully sent
- busy  out  1  high while a frame is in progress
- overrun  out  1  sticky: at least one request dropped since reset

Behaviour:
- Reset (async assert, sync release): state IDLE; tx_start=0, tx_data=0x00, busy=0, overrun=0, cycle_cnt=0, byte index=0, drop flag=0.
- cycle_cnt: 32-bit, increments every clk after reset; wraps 0xFFFFFFFF->0.
- IDLE, wr_uart=1:
  - capture {pc_in, acc_in, cycle_cnt}, with cycle_cnt taken as the register value at that edge;
  - clear drop flag into the header;
  - go to LOAD; busy=1 from the next cycle.
  - wr_uart held high N cycles = one capture plus (N-1) drops. The strobe is level-sampled, not edge-detected.
- Frame bytes, in order (index 0..9):
  - 0: header. 0xA5 if no request was dropped since the previous capture, else 0xA7.
  - 1-2: PC, MSB first.
  - 3-4: ACC, MSB first.
  - 5-8: cycle count, MSB first.
  - 9: checksum = XOR of bytes 1..8.
- LOAD: drive tx_data=frame[idx], tx_start=1 for exactly one cycle, then go to WAIT.
- WAIT: hold tx_data.
  - tx_done=1 and idx<9: idx++ and go to LOAD. Next tx_start is exactly 1 cycle after tx_done.
  - tx_done=1 and idx=9: go to IDLE, busy=0 next cycle, idx=0.
- tx_done in the LOAD cycle or in IDLE is ignored.
- Throughput: 10 tx_start pulses per frame. Latency from the capturing wr_uart edge to the first tx_start is 1 cycle.
- wr_uart while busy=1, or in the cycle the FSM returns to IDLE: request dropped; drop flag=1; overrun=1, sticky until reset.
- The snapshot is frozen for the whole frame. pc_in/acc_in changes during transmission have no effect.
- Reset mid-frame: abort immediately, all outputs go to reset values, and the partial frame is not resumed.
- Checksum uses the zero-extended 16-bit fields.

Decomposition:
- Shared package holds:
  - HDR_OK=8'hA5, HDR_DROP=8'hA7, FRAME_LEN=10;
  - FSM state encoding IDLE/LOAD/WAIT;
  - byte-index constants.
- Natural sub-module: dbg_cycle_counter (32-bit free-running counter with async active-low reset). The FSM, snapshot registers and byte mux stay in uart_debug_dumper.

Test Plan:
1. Basic frame:
   - Stimulus: reset, then wr_uart=1 for 1 cycle when cycle_cnt=0x00000010, with pc_in=0x005, acc_in=0x1234. TX model returns tx_done 16 cycles after each tx_start.
   - Required: bytes A5 00 05 12 34 00 00 00 10 33; busy=0 after the last done.
2. Drop and overrun:
   - Stimulus: second wr_uart pulse during byte 3 of a frame.
   - Required: overrun=1; the current frame is unaffected; the next requested frame header is 0xA7; the frame after that is 0xA5.
3. Held strobe:
   - Stimulus: wr_uart held high 5 cycles.
   - Required: exactly one frame; overrun=1.
4. Handshake timing:
   - Stimulus: tx_done pulsed in the same cycle as tx_start; later, a stray tx_done in IDLE.
   - Required: both ignored, no byte skipped. Each tx_start is 1 cycle wide, and tx_data is stable from tx_start until tx_done.
5. Reset mid-frame:
   - Stimulus: rst_n low asynchronously (between edges) during byte 6.
   - Required: tx_start=0, busy=0, overrun=0 immediately; next frame starts at header 0xA5.
6. Wrap:
   - Stimulus: force cycle_cnt=0xFFFFFFFF.
   - Required: next value 0x00000000; a frame captured at 0xFFFFFFFF carries FF FF FF FF, with checksum matching the XOR of bytes 1..8.
